// File: rtl/parametric_register_file_if.sv
// Bus bundle for the parametric register file: write controls, data,
// read-port selects and the read/flag results.
//
// Handshake: there is no valid/ready pair. A write is requested by holding
// enable=1 with regSel/funSel/i stable across a rising clock edge and is
// always accepted on that edge. Read results are continuously valid and
// combinational in outASel/outBSel.
interface parametric_register_file_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4
);
  localparam int SELW = $clog2(NUM_REGS);

  logic                enable;
  logic [NUM_REGS-1:0] regSel;
  logic [2:0]          funSel;
  logic [WIDTH-1:0]    i;
  logic [SELW-1:0]     outASel;
  logic [SELW-1:0]     outBSel;
  logic [WIDTH-1:0]    outA;
  logic [WIDTH-1:0]    outB;
  logic                wrapFlag;

  modport master (
    output enable, regSel, funSel, i, outASel, outBSel,
    input  outA, outB, wrapFlag
  );

  modport slave (
    input  enable, regSel, funSel, i, outASel, outBSel,
    output outA, outB, wrapFlag
  );
endinterface

// File: rtl/parametric_register_file.sv
// Bank of NUM_REGS registers of WIDTH bits with a bitmask write select,
// eight load/arith operations, two combinational read ports and a
// registered inc/dec wrap flag.
module parametric_register_file #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4
) (
  input  logic                      clock,
  input  logic                      resetN,
  parametric_register_file_if.slave bus
);
  localparam int SELW = $clog2(NUM_REGS);
  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]    regs     [NUM_REGS];
  logic [WIDTH-1:0]    nxt      [NUM_REGS];
  logic [NUM_REGS-1:0] wrap_hit;
  logic                wrap_q;
  logic [WIDTH-1:0]    out_a;
  logic [WIDTH-1:0]    out_b;

  // Result of one operation on one register; every register uses the same op.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] v;
    v = '0;
    case (op)
      3'b000:  v = r - ONE;
      3'b001:  v = r + ONE;
      3'b010:  v = d;
      3'b011:  v = '0;
      3'b100:  v = {{HALF{1'b0}}, d[HALF-1:0]};
      3'b101:  v = {r[WIDTH-1:HALF], d[HALF-1:0]};
      3'b110:  v = {d[HALF-1:0], r[HALF-1:0]};
      default: v = {{HALF{d[HALF-1]}}, d[HALF-1:0]};
    endcase
    return v;
  endfunction

  // Next value and wrap detection for each register from its own current value.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      nxt[k]      = apply_op(bus.funSel, regs[k], bus.i);
      wrap_hit[k] = bus.regSel[k] &
                    (((bus.funSel == 3'b000) && (regs[k] == '0)) ||
                     ((bus.funSel == 3'b001) && (regs[k] == '1)));
    end
  end

  // Register array and wrap flag; flag is re-evaluated on every enabled edge.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      wrap_q <= 1'b0;
    end else if (bus.enable) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (bus.regSel[k]) regs[k] <= nxt[k];
      end
      wrap_q <= |wrap_hit;
    end
  end

  // Read ports; an index with no register behind it reads as zero.
  always_comb begin
    out_a = '0;
    out_b = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (bus.outASel == SELW'(k)) out_a = regs[k];
      if (bus.outBSel == SELW'(k)) out_b = regs[k];
    end
  end

  assign bus.outA     = out_a;
  assign bus.outB     = out_b;
  assign bus.wrapFlag = wrap_q;
endmodule

// File: tb/tb_parametric_register_file.sv
// Bench for parametric_register_file: a 4-register and a 3-register instance
// driven with directed sequences and random traffic, compared every cycle
// against an arithmetic model of the register bank.
module tb_parametric_register_file;
  logic clock  = 1'b0;
  logic resetN = 1'b0;
  logic check_on = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // clock / interfaces / DUTs
  always #5 clock = ~clock;

  parametric_register_file_if #(.WIDTH(16), .NUM_REGS(4)) b4 ();
  parametric_register_file_if #(.WIDTH(16), .NUM_REGS(3)) b3 ();

  parametric_register_file #(.WIDTH(16), .NUM_REGS(4)) dut4 (
    .clock(clock), .resetN(resetN), .bus(b4)
  );
  parametric_register_file #(.WIDTH(16), .NUM_REGS(3)) dut3 (
    .clock(clock), .resetN(resetN), .bus(b3)
  );

  // reference model: plain integer arithmetic on 16-bit values
  int m4 [4] = '{default: 0};
  int m3 [3] = '{default: 0};
  bit w4 = 1'b0;
  bit w3 = 1'b0;

  function automatic int op_model(input int r, input int op, input int d);
    int lo  = d % 256;
    int hi  = r / 256;
    int rlo = r % 256;
    case (op)
      0: return (r + 65535) % 65536;
      1: return (r + 1) % 65536;
      2: return d;
      3: return 0;
      4: return lo;
      5: return hi * 256 + lo;
      6: return lo * 256 + rlo;
      default: return (lo >= 128) ? 65280 + lo : lo;
    endcase
  endfunction

  function automatic bit wraps(input int r, input int op);
    return (op == 0 && r == 0) || (op == 1 && r == 65535);
  endfunction

  function automatic bit any_wrap4();
    bit w = 1'b0;
    for (int k = 0; k < 4; k++)
      if (b4.regSel[k] && wraps(m4[k], int'(b4.funSel))) w = 1'b1;
    return w;
  endfunction

  function automatic bit any_wrap3();
    bit w = 1'b0;
    for (int k = 0; k < 3; k++)
      if (b3.regSel[k] && wraps(m3[k], int'(b3.funSel))) w = 1'b1;
    return w;
  endfunction

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < 4; k++) m4[k] <= 0;
      for (int k = 0; k < 3; k++) m3[k] <= 0;
      w4 <= 1'b0;
      w3 <= 1'b0;
    end else begin
      if (b4.enable) begin
        for (int k = 0; k < 4; k++)
          if (b4.regSel[k]) m4[k] <= op_model(m4[k], int'(b4.funSel), int'(b4.i));
        w4 <= any_wrap4();
      end
      if (b3.enable) begin
        for (int k = 0; k < 3; k++)
          if (b3.regSel[k]) m3[k] <= op_model(m3[k], int'(b3.funSel), int'(b3.i));
        w3 <= any_wrap3();
      end
    end
  end

  // scoreboard check
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: DUT outputs against the model every cycle
  initial begin
    forever begin
      @(negedge clock);
      if (check_on) begin
        chk("cmp4_outA", b4.outA, 16'(m4[b4.outASel]));
        chk("cmp4_outB", b4.outB, 16'(m4[b4.outBSel]));
        chk("cmp4_wrap", {15'd0, b4.wrapFlag}, {15'd0, w4});
        chk("cmp3_outA", b3.outA, (b3.outASel < 2'd3) ? 16'(m3[b3.outASel]) : 16'h0000);
        chk("cmp3_outB", b3.outB, (b3.outBSel < 2'd3) ? 16'(m3[b3.outBSel]) : 16'h0000);
        chk("cmp3_wrap", {15'd0, b3.wrapFlag}, {15'd0, w3});
      end
    end
  end

  // drivers: called just after a rising edge; one write edge, then idle
  task automatic apply4(input logic en, input logic [3:0] sel, input logic [2:0] fun,
                        input logic [15:0] d);
    b4.enable = en; b4.regSel = sel; b4.funSel = fun; b4.i = d;
    @(posedge clock); #1;
    b4.enable = 1'b0;
  endtask

  task automatic apply3(input logic en, input logic [2:0] sel, input logic [2:0] fun,
                        input logic [15:0] d);
    b3.enable = en; b3.regSel = sel; b3.funSel = fun; b3.i = d;
    @(posedge clock); #1;
    b3.enable = 1'b0;
  endtask

  task automatic rd4(input logic [1:0] a, input logic [1:0] b);
    b4.outASel = a; b4.outBSel = b; #1;
  endtask

  task automatic rd3(input logic [1:0] a, input logic [1:0] b);
    b3.outASel = a; b3.outBSel = b; #1;
  endtask

  function automatic logic [15:0] rand_data();
    case ($urandom_range(0, 3))
      0: return 16'h0000;
      1: return 16'hFFFF;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  // main sequence
  initial begin
    b4.enable = 1'b0; b4.regSel = '0; b4.funSel = '0; b4.i = '0;
    b4.outASel = '0; b4.outBSel = '0;
    b3.enable = 1'b0; b3.regSel = '0; b3.funSel = '0; b3.i = '0;
    b3.outASel = '0; b3.outBSel = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outA", b4.outA, 16'h0000);
    chk("reset_wrap", {15'd0, b4.wrapFlag}, 16'h0000);
    resetN = 1'b1;
    check_on = 1'b1;

    // asynchronous reset mid-cycle
    apply4(1'b1, 4'b0001, 3'b010, 16'h1234);
    rd4(2'd0, 2'd0);
    chk("load_r0", b4.outA, 16'h1234);
    resetN = 1'b0; #1;
    chk("async_reset_outA", b4.outA, 16'h0000);
    @(posedge clock); #1;
    resetN = 1'b1;

    // hold while disabled
    apply4(1'b0, 4'b1111, 3'b001, 16'h0000);
    apply4(1'b0, 4'b1111, 3'b001, 16'h0000);
    apply4(1'b0, 4'b1111, 3'b001, 16'h0000);
    rd4(2'd0, 2'd1);
    chk("hold_r0", b4.outA, 16'h0000);
    chk("hold_r1", b4.outB, 16'h0000);
    rd4(2'd2, 2'd3);
    chk("hold_r2", b4.outA, 16'h0000);
    chk("hold_r3", b4.outB, 16'h0000);
    chk("hold_wrap", {15'd0, b4.wrapFlag}, 16'h0000);

    // wrap both ways on R1
    apply4(1'b1, 4'b0010, 3'b000, 16'h0000);
    rd4(2'd1, 2'd1);
    chk("dec_wrap_val", b4.outA, 16'hFFFF);
    chk("dec_wrap_flag", {15'd0, b4.wrapFlag}, 16'h0001);
    apply4(1'b1, 4'b0010, 3'b001, 16'h0000);
    chk("inc_wrap_val", b4.outA, 16'h0000);
    chk("inc_wrap_flag", {15'd0, b4.wrapFlag}, 16'h0001);
    apply4(1'b1, 4'b0010, 3'b001, 16'h0000);
    chk("inc_val", b4.outA, 16'h0001);
    chk("inc_flag", {15'd0, b4.wrapFlag}, 16'h0000);

    // half-word and sign-extend modes on R2
    rd4(2'd2, 2'd2);
    apply4(1'b1, 4'b0100, 3'b010, 16'h1234);
    chk("r2_load", b4.outA, 16'h1234);
    apply4(1'b1, 4'b0100, 3'b110, 16'h00AB);
    chk("r2_load_high", b4.outA, 16'hAB34);
    apply4(1'b1, 4'b0100, 3'b101, 16'h00CD);
    chk("r2_load_low_keep", b4.outA, 16'hABCD);
    apply4(1'b1, 4'b0100, 3'b100, 16'hFF80);
    chk("r2_load_low_zero", b4.outA, 16'h0080);
    apply4(1'b1, 4'b0100, 3'b111, 16'h0080);
    chk("r2_sext_neg", b4.outA, 16'hFF80);
    apply4(1'b1, 4'b0100, 3'b111, 16'h007F);
    chk("r2_sext_pos", b4.outA, 16'h007F);

    // multi-select
    apply4(1'b1, 4'b1011, 3'b010, 16'h5A5A);
    rd4(2'd0, 2'd1);
    chk("multi_r0", b4.outA, 16'h5A5A);
    chk("multi_r1", b4.outB, 16'h5A5A);
    rd4(2'd2, 2'd3);
    chk("multi_r2", b4.outA, 16'h007F);
    chk("multi_r3", b4.outB, 16'h5A5A);
    apply4(1'b1, 4'b0001, 3'b011, 16'hFFFF);
    rd4(2'd0, 2'd3);
    chk("clear_r0", b4.outA, 16'h0000);
    chk("clear_r3", b4.outB, 16'h5A5A);

    // wrap flag: empty enabled write clears, disabled edge holds
    apply4(1'b1, 4'b0001, 3'b000, 16'h0000);
    chk("r0_dec_wrap", {15'd0, b4.wrapFlag}, 16'h0001);
    apply4(1'b1, 4'b0000, 3'b001, 16'h0000);
    chk("empty_write_clears", {15'd0, b4.wrapFlag}, 16'h0000);
    chk("empty_write_r0", b4.outA, 16'hFFFF);
    apply4(1'b1, 4'b0001, 3'b001, 16'h0000);
    apply4(1'b0, 4'b0001, 3'b011, 16'h0000);
    chk("disabled_holds_wrap", {15'd0, b4.wrapFlag}, 16'h0001);

    // read during write: no bypass
    apply4(1'b1, 4'b1000, 3'b010, 16'h0010);
    rd4(2'd3, 2'd3);
    b4.enable = 1'b1; b4.regSel = 4'b1000; b4.funSel = 3'b001; #1;
    chk("rdw_before_a", b4.outA, 16'h0010);
    chk("rdw_before_b", b4.outB, 16'h0010);
    @(posedge clock); #1;
    b4.enable = 1'b0;
    chk("rdw_after_a", b4.outA, 16'h0011);
    chk("rdw_after_b", b4.outB, 16'h0011);

    // three-register instance
    rd3(2'd0, 2'd3);
    apply3(1'b1, 3'b111, 3'b010, 16'h0C3C);
    chk("n3_oob_read", b3.outB, 16'h0000);
    chk("n3_r0", b3.outA, 16'h0C3C);
    rd3(2'd1, 2'd2);
    chk("n3_r1", b3.outA, 16'h0C3C);
    chk("n3_r2", b3.outB, 16'h0C3C);

    // random traffic on both instances
    for (int n = 0; n < 600; n++) begin
      b4.enable  = ($urandom_range(0, 3) != 0);
      b4.regSel  = 4'($urandom_range(0, 15));
      b4.funSel  = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 1))
                                               : 3'($urandom_range(0, 7));
      b4.i       = rand_data();
      b4.outASel = 2'($urandom_range(0, 3));
      b4.outBSel = 2'($urandom_range(0, 3));
      b3.enable  = ($urandom_range(0, 3) != 0);
      b3.regSel  = 3'($urandom_range(0, 7));
      b3.funSel  = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 1))
                                               : 3'($urandom_range(0, 7));
      b3.i       = rand_data();
      b3.outASel = 2'($urandom_range(0, 3));
      b3.outBSel = 2'($urandom_range(0, 3));
      if (n == 300) begin
        resetN = 1'b0; #2;
        resetN = 1'b1;
      end
      @(posedge clock); #1;
    end
    b4.enable = 1'b0;
    b3.enable = 1'b0;
    @(posedge clock); #1;
    @(negedge clock); #1;
    check_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/parametric_register_file.md
# parametric_register_file

Parametrised bank of `NUM_REGS` general-purpose registers, each `WIDTH` bits wide, that generalises the single 16-bit function-select register. Adds multi-register write select, two independent read ports, half-word load modes, sign-extended load and a registered wrap flag for increment/decrement. It is the datapath register block that feeds the ALU operand muxes in the next CPU iteration.

## Interface
Parameters:
- `WIDTH`, default 16: register width; must be even and at least 4. `HALF = WIDTH/2`.
- `NUM_REGS`, default 4: number of registers; must be at least 2. `SELW = $clog2(NUM_REGS)`.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global write enable; 0 means no register and no flag changes.
- `regSel`  in  NUM_REGS  write bitmask; bit k set selects register k (any number of bits may be set).
- `funSel`  in  3  operation applied to every selected register.
- `i`  in  WIDTH  data input.
- `outASel`  in  SELW  read-port A index.
- `outBSel`  in  SELW  read-port B index.
- `outA`  out  WIDTH  contents of register `outASel`.
- `outB`  out  WIDTH  contents of register `outBSel`.
- `wrapFlag`  out  1  registered; set when an inc/dec wrapped in the last enabled write.

## Operation
- `funSel` encoding, where R is the selected register, L = `i[HALF-1:0]` and H = `R[WIDTH-1:HALF]`:
  - 000 decrement: R = R - 1, modulo 2^WIDTH.
  - 001 increment: R = R + 1, modulo 2^WIDTH.
  - 010 load: R = `i`.
  - 011 clear: R = 0.
  - 100 load low, zero upper: R = {0, L}.
  - 101 load low, keep upper: R = {H, L}.
  - 110 load high, keep lower: R = {L, R[HALF-1:0]} (the low half of `i` goes to the upper half of R).
  - 111 sign-extend low: R = {HALF copies of `i[HALF-1]`, L}.
- A register updates only when `enable`=1 and its `regSel` bit is 1. Unselected registers hold.
- When several registers are selected, each applies the same op to its own current value. There is no cross-register dependency.
- `enable`=1 with `regSel`=0: no register changes, and `wrapFlag` is cleared (counts as an enabled write with no wrap).
- `wrapFlag` is evaluated at every enabled edge:
  - Set to 1 if any selected register either decremented from 0 to all-ones or incremented from all-ones to 0.
  - Otherwise cleared to 0.
  - Held while `enable`=0.
- Read ports are combinational from the register array and show pre-edge values during the write cycle.
- A read index of NUM_REGS or higher (non-power-of-two `NUM_REGS`) drives all zeros.

## Timing
- Reset: `resetN` low immediately forces all registers to 0 and `wrapFlag` to 0, independent of `clock`, so `outA`=`outB`=0.
  - Asserting reset mid-sequence aborts any pending write.
  - The first edge after `resetN` rises is a normal edge.
- Write latency: 1 cycle. The new value is visible on `outA`/`outB` just after the rising edge that samples `enable`.
- Read latency: 0 cycles; output follows a select change within the same cycle.
- Read-during-write to the same index returns the old value until the edge. There is no bypass.
- `wrapFlag` updates on the same edge as the register write it describes.
- Inputs are sampled only at the rising edge; glitches between edges have no effect.

## Test plan
Use WIDTH=16, NUM_REGS=4 unless noted.
- **Reset and hold.** Drive `resetN`=0 mid-cycle after loading R0=0x1234 → `outA`=0x0000 immediately, before the next edge. Then `enable`=0, `funSel`=001 for 3 edges → all registers stay 0 and `wrapFlag`=0.
- **Wrap both ways.** On R1=0, `regSel`=0010, `funSel`=000 → R1=0xFFFF, `wrapFlag`=1. Next edge `funSel`=001 → R1=0x0000, `wrapFlag`=1. Next edge `funSel`=001 → R1=0x0001, `wrapFlag`=0.
- **Half and sign-extend modes on R2.**
  - Load 0x1234.
  - `funSel`=110, `i`=0x00AB → 0xAB34.
  - `funSel`=101, `i`=0x00CD → 0xABCD.
  - `funSel`=100, `i`=0xFF80 → 0x0080.
  - `funSel`=111, `i`=0x0080 → 0xFF80.
  - `funSel`=111, `i`=0x007F → 0x007F.
- **Multi-select.** `regSel`=1011, `funSel`=010, `i`=0x5A5A → R0, R1 and R3 = 0x5A5A, R2 unchanged. Then `funSel`=011 with `regSel`=0001 → R0=0, R3 still 0x5A5A.
- **Read-during-write.** R3=0x0010, `outASel`=3, `outBSel`=3, increment R3 → both ports show 0x0010 before the edge and 0x0011 after it.
- **NUM_REGS=3 instance.** `outBSel`=3 → `outB`=0x0000. Writing with `regSel`=111 updates all three registers.
